// File: rtl/rv32i_types.sv
// Shared RV32I type package: line-buffer FSM encoding, geometry constants and a
// word-select helper used by the instruction-side line buffer.
package rv32i_types;

  // Geometry of one line-buffer entry.
  localparam int unsigned LBUF_LINE_BITS   = 256;
  localparam int unsigned LBUF_OFFSET_BITS = 5;
  localparam int unsigned LBUF_TAG_BITS    = 32 - LBUF_OFFSET_BITS;

  typedef enum logic [1:0] {
    LB_IDLE,
    LB_MISS,
    LB_PREFETCH
  } lbuf_state_t;

  // Select 32-bit word idx from a line; word w lives at bits [32w+31:32w].
  function automatic logic [31:0] lbuf_word(input logic [LBUF_LINE_BITS-1:0] line,
                                            input logic [2:0]                idx);
    return line[{idx, 5'b00000} +: 32];
  endfunction

endpackage

// File: rtl/lbuf_entry.sv
// One line-buffer entry: valid bit, line tag and 256-bit line data, plus a
// tag comparator against the current lookup tag.
// Ports:
//   clk, rst   - clock and synchronous active-high reset (clears valid)
//   load       - write tag_in/data_in and set valid
//   clear      - clear valid; takes priority over load
//   tag_in     - tag to store on load
//   data_in    - line to store on load
//   lookup_tag - tag being looked up
//   valid      - entry holds a line
//   tag        - stored tag
//   data       - stored line
//   tag_match  - valid and stored tag equals lookup_tag
module lbuf_entry
  import rv32i_types::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic                      clear,
  input  logic [LBUF_TAG_BITS-1:0]  tag_in,
  input  logic [LBUF_LINE_BITS-1:0] data_in,
  input  logic [LBUF_TAG_BITS-1:0]  lookup_tag,
  output logic                      valid,
  output logic [LBUF_TAG_BITS-1:0]  tag,
  output logic [LBUF_LINE_BITS-1:0] data,
  output logic                      tag_match
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
    end
  end

  // Payload needs no reset: it is only observed through a valid tag match.
  always_ff @(posedge clk) begin
    if (load) begin
      tag  <= tag_in;
      data <= data_in;
    end
  end

  assign tag_match = valid && (tag == lookup_tag);

endmodule

// File: rtl/register.sv
// Generic load-enabled register with synchronous active-high reset to zero.
// Ports:
//   clk  - clock
//   rst  - synchronous reset, clears the register
//   load - capture din on the rising edge
//   din  - next value
//   dout - registered value
module register #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  always_ff @(posedge clk) begin
    if (rst) begin
      dout <= '0;
    end else if (load) begin
      dout <= din;
    end
  end

endmodule

// File: rtl/imem_line_buffer.sv
// Instruction-side line buffer. Serves word-aligned 32-bit fetches from two
// resident 256-bit lines, fills from the I-cache on a miss and optionally
// prefetches the sequential next line after each demand fill.
// Ports:
//   clk, rst       - clock and synchronous active-high reset
//   imem_read      - fetch request valid
//   imem_addr      - fetch address, bits [1:0] ignored
//   inval          - one-cycle pulse, invalidates both lines
//   imem_rdata     - fetched word, meaningful when ready=1
//   ready          - combinational hit for the current request
//   icache_read    - line read request to the I-cache (registered)
//   icache_address - line-aligned request address (registered)
//   icache_rdata   - returned line
//   icache_resp    - single-cycle completion of icache_read
module imem_line_buffer
  import rv32i_types::*;
#(
  parameter bit PREFETCH = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      imem_read,
  input  logic [31:0]               imem_addr,
  input  logic                      inval,
  output logic [31:0]               imem_rdata,
  output logic                      ready,
  output logic                      icache_read,
  output logic [31:0]               icache_address,
  input  logic [LBUF_LINE_BITS-1:0] icache_rdata,
  input  logic                      icache_resp
);

  lbuf_state_t state, state_next;

  logic [31:0] addr_q, addr_d;
  logic        addr_load;
  logic        lru_q, lru_d;
  logic        lru_load;
  logic        victim_q, victim_d;
  // Set when inval hits an outstanding fill; the returning line is dropped.
  logic        discard_q, discard_d;

  logic [LBUF_TAG_BITS-1:0]  req_tag;
  logic [LBUF_TAG_BITS-1:0]  fill_tag;
  logic [LBUF_TAG_BITS-1:0]  next_tag;
  logic [1:0]                ent_valid;
  logic [1:0]                ent_match;
  logic [1:0]                ent_load;
  logic [LBUF_TAG_BITS-1:0]  ent_tag  [2];
  logic [LBUF_LINE_BITS-1:0] ent_data [2];

  logic any_match;
  logic hit_idx;
  logic drop;
  logic fill_ok;
  logic other_has_next;
  logic unused_addr_bits;

  assign req_tag  = imem_addr[31:LBUF_OFFSET_BITS];
  assign fill_tag = addr_q[31:LBUF_OFFSET_BITS];
  assign next_tag = fill_tag + {{(LBUF_TAG_BITS-1){1'b0}}, 1'b1};  // wraps mod 2^27

  assign unused_addr_bits = ^imem_addr[1:0];

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  assign drop    = inval || discard_q;
  assign fill_ok = icache_resp && !drop && (state != LB_IDLE);

  assign ent_load[0] = fill_ok && !victim_q;
  assign ent_load[1] = fill_ok &&  victim_q;

  lbuf_entry u_entry0 (
    .clk        (clk),
    .rst        (rst),
    .load       (ent_load[0]),
    .clear      (inval),
    .tag_in     (fill_tag),
    .data_in    (icache_rdata),
    .lookup_tag (req_tag),
    .valid      (ent_valid[0]),
    .tag        (ent_tag[0]),
    .data       (ent_data[0]),
    .tag_match  (ent_match[0])
  );

  lbuf_entry u_entry1 (
    .clk        (clk),
    .rst        (rst),
    .load       (ent_load[1]),
    .clear      (inval),
    .tag_in     (fill_tag),
    .data_in    (icache_rdata),
    .lookup_tag (req_tag),
    .valid      (ent_valid[1]),
    .tag        (ent_tag[1]),
    .data       (ent_data[1]),
    .tag_match  (ent_match[1])
  );

  register #(
    .WIDTH (32)
  ) u_addr_reg (
    .clk  (clk),
    .rst  (rst),
    .load (addr_load),
    .din  (addr_d),
    .dout (addr_q)
  );

  register #(
    .WIDTH (1)
  ) u_lru_reg (
    .clk  (clk),
    .rst  (rst),
    .load (lru_load),
    .din  (lru_d),
    .dout (lru_q)
  );

  // ---------------------------------------------------------------------------
  // Lookup
  // ---------------------------------------------------------------------------
  assign any_match = ent_match[0] || ent_match[1];
  assign hit_idx   = !ent_match[0];
  assign ready     = imem_read && (state != LB_MISS) && !inval && any_match;

  always_comb begin
    imem_rdata = '0;
    if (ent_match[0]) begin
      imem_rdata = lbuf_word(ent_data[0], imem_addr[4:2]);
    end else if (ent_match[1]) begin
      imem_rdata = lbuf_word(ent_data[1], imem_addr[4:2]);
    end
  end

  // The freshly filled victim never holds tag+1, so only the other entry matters.
  assign other_has_next = victim_q ? (ent_valid[0] && (ent_tag[0] == next_tag))
                                   : (ent_valid[1] && (ent_tag[1] == next_tag));

  assign icache_read    = (state != LB_IDLE);
  assign icache_address = addr_q;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LB_IDLE;
      victim_q  <= 1'b0;
      discard_q <= 1'b0;
    end else begin
      state     <= state_next;
      victim_q  <= victim_d;
      discard_q <= discard_d;
    end
  end

  always_comb begin
    state_next = state;
    addr_d     = addr_q;
    addr_load  = 1'b0;
    lru_d      = lru_q;
    lru_load   = 1'b0;
    victim_d   = victim_q;
    discard_d  = discard_q;

    if (ready) begin
      lru_d    = !hit_idx;
      lru_load = 1'b1;
    end

    case (state)
      LB_IDLE: begin
        discard_d = 1'b0;
        if (imem_read && !inval && !any_match) begin
          addr_d     = {req_tag, {LBUF_OFFSET_BITS{1'b0}}};
          addr_load  = 1'b1;
          victim_d   = lru_q;
          state_next = LB_MISS;
        end
      end

      LB_MISS: begin
        if (inval) begin
          discard_d = 1'b1;
        end
        if (icache_resp) begin
          state_next = LB_IDLE;
          if (!drop) begin
            lru_d    = !victim_q;
            lru_load = 1'b1;
            if (PREFETCH && !other_has_next) begin
              addr_d     = {next_tag, {LBUF_OFFSET_BITS{1'b0}}};
              addr_load  = 1'b1;
              victim_d   = !victim_q;
              state_next = LB_PREFETCH;
            end
          end
        end
      end

      LB_PREFETCH: begin
        if (inval) begin
          discard_d = 1'b1;
        end
        if (icache_resp) begin
          state_next = LB_IDLE;
        end
      end

      default: state_next = LB_IDLE;
    endcase
  end

endmodule

// File: tb/tb_imem_line_buffer.sv
module tb_imem_line_buffer;

  localparam bit PF = 1'b1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         imem_read = 1'b0;
  logic [31:0]  imem_addr = '0;
  logic         inval = 1'b0;
  logic [31:0]  imem_rdata;
  logic         ready;
  logic         icache_read;
  logic [31:0]  icache_address;
  logic [255:0] icache_rdata = '0;
  logic         icache_resp = 1'b0;

  always #5 clk = ~clk;

  imem_line_buffer #(
    .PREFETCH (PF)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_read      (imem_read),
    .imem_addr      (imem_addr),
    .inval          (inval),
    .imem_rdata     (imem_rdata),
    .ready          (ready),
    .icache_read    (icache_read),
    .icache_address (icache_address),
    .icache_rdata   (icache_rdata),
    .icache_resp    (icache_resp)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: two resident lines, an lru pointer and one outstanding fill.
  bit          m_v [2];
  logic [26:0] m_t [2];
  bit          m_lru;
  bit          m_busy, m_demand, m_discard, m_slot;
  logic [26:0] m_ptag;

  // Backing instruction memory, indexed by word address.
  function automatic logic [31:0] mem_word(input logic [29:0] wa);
    logic [31:0] x;
    if (wa == 30'h41) return 32'hDEADBEEF;
    x = {wa, 2'b01};
    return (x * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  function automatic logic [255:0] line_of(input logic [26:0] tag);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[32*w +: 32] = mem_word({tag, 3'(w)});
    return l;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_v[0] = 1'b0; m_v[1] = 1'b0; m_t[0] = '0; m_t[1] = '0;
    m_lru = 1'b0; m_busy = 1'b0; m_demand = 1'b0; m_discard = 1'b0;
    m_slot = 1'b0; m_ptag = '0;
  endtask

  // One clock cycle: drive inputs, check outputs at negedge, advance model at posedge.
  task automatic step(input bit r, input logic [31:0] a, input bit iv, input bit rs, input bit rr);
    bit h0, h1, hitok;
    logic [26:0] nt;
    imem_read = r; imem_addr = a; inval = iv; icache_resp = rs; rst = rr;
    icache_rdata = m_busy ? line_of(m_ptag) : {8{32'hBAD0BAD0}};
    h0 = m_v[0] && (m_t[0] == a[31:5]);
    h1 = m_v[1] && (m_t[1] == a[31:5]);
    hitok = r && !(m_busy && m_demand) && !iv && (h0 || h1);
    @(negedge clk);
    check_eq("ready", 32'(ready), 32'(hitok));
    if (hitok) check_eq("rdata", imem_rdata, mem_word(a[31:2]));
    check_eq("icache_read", 32'(icache_read), 32'(m_busy));
    if (m_busy) check_eq("icache_address", icache_address, {m_ptag, 5'b0});
    @(posedge clk);
    if (rr) begin
      model_reset();
    end else begin
      if (hitok) m_lru = h0 ? 1'b1 : 1'b0;
      if (iv) begin m_v[0] = 1'b0; m_v[1] = 1'b0; end
      if (m_busy) begin
        if (iv) m_discard = 1'b1;
        if (rs) begin
          if (m_discard) begin
            m_busy = 1'b0;
          end else begin
            m_v[m_slot] = 1'b1;
            m_t[m_slot] = m_ptag;
            if (m_demand) begin
              m_lru = !m_slot;
              nt = m_ptag + 27'd1;
              if (PF && !(m_v[!m_slot] && (m_t[!m_slot] == nt))) begin
                m_ptag = nt; m_slot = !m_slot; m_demand = 1'b0;
              end else begin
                m_busy = 1'b0;
              end
            end else begin
              m_busy = 1'b0;
            end
          end
        end
      end else if (r && !iv && !h0 && !h1) begin
        m_busy = 1'b1; m_demand = 1'b1; m_ptag = a[31:5]; m_slot = m_lru; m_discard = 1'b0;
      end
      if (!m_busy) m_discard = 1'b0;
    end
    #1;
  endtask

  initial begin
    logic [26:0] pool [7];
    pool[0] = 27'h8; pool[1] = 27'h9; pool[2] = 27'hA; pool[3] = 27'hB;
    pool[4] = 27'h7FFFFFF; pool[5] = 27'h0; pool[6] = 27'hC;
    model_reset();
    @(posedge clk); #1;

    // Reset state
    step(0, 32'h0, 0, 0, 1);
    check_eq("rst_iread", 32'(icache_read), 32'd0);
    check_eq("rst_iaddr", icache_address, 32'h0);
    check_eq("rst_ready", 32'(ready), 32'd0);
    check_eq("rst_rdata", imem_rdata, 32'h0);

    // Cold miss then prefetch of the next line
    step(1, 32'h104, 0, 0, 0);
    check_eq("cold_iread", 32'(icache_read), 32'd1);
    check_eq("cold_iaddr", icache_address, 32'h100);
    step(1, 32'h104, 0, 1, 0);
    check_eq("cold_ready", 32'(ready), 32'd1);
    check_eq("cold_rdata", imem_rdata, 32'hDEADBEEF);
    check_eq("pf_iread", 32'(icache_read), 32'd1);
    check_eq("pf_iaddr", icache_address, 32'h120);
    step(1, 32'h100, 0, 0, 0);
    check_eq("pf_hit_ready", 32'(ready), 32'd1);
    step(1, 32'h124, 0, 0, 0);
    check_eq("pf_wait_ready", 32'(ready), 32'd0);
    step(1, 32'h124, 0, 1, 0);
    check_eq("pf_done_ready", 32'(ready), 32'd1);
    check_eq("pf_done_rdata", imem_rdata, mem_word(30'h49));

    // LRU: 0x100 most recent, miss to 0x200 evicts 0x120
    step(1, 32'h100, 0, 0, 0);
    step(1, 32'h200, 0, 0, 0);
    check_eq("lru_iaddr", icache_address, 32'h200);
    step(1, 32'h200, 0, 1, 0);
    check_eq("lru_pf_iaddr", icache_address, 32'h220);
    step(1, 32'h120, 0, 0, 0);
    check_eq("lru_evicted", 32'(ready), 32'd0);
    step(1, 32'h100, 0, 0, 0);
    check_eq("lru_kept", 32'(ready), 32'd1);
    step(0, 32'h0, 0, 1, 0);

    // Invalidate during a demand fill
    step(1, 32'h300, 0, 0, 0);
    step(0, 32'h300, 1, 0, 0);
    step(0, 32'h300, 0, 1, 0);
    check_eq("inv_iread", 32'(icache_read), 32'd0);
    step(1, 32'h300, 0, 0, 0);
    check_eq("inv_remiss", 32'(icache_read), 32'd1);
    check_eq("inv_remiss_addr", icache_address, 32'h300);
    step(0, 32'h300, 0, 1, 0);
    step(0, 32'h0, 0, 1, 0);

    // Tag wrap on prefetch
    step(1, 32'hFFFFFFE0, 0, 0, 0);
    step(1, 32'hFFFFFFE0, 0, 1, 0);
    check_eq("wrap_iread", 32'(icache_read), 32'd1);
    check_eq("wrap_iaddr", icache_address, 32'h0);

    // Reset during prefetch, then a stale response
    step(0, 32'h0, 0, 0, 1);
    check_eq("rstpf_iread", 32'(icache_read), 32'd0);
    step(0, 32'h0, 0, 1, 0);
    imem_read = 1'b1; imem_addr = 32'hFFFFFFE4;
    #1;
    check_eq("stale_ready", 32'(ready), 32'd0);
    check_eq("stale_iread", 32'(icache_read), 32'd0);
    imem_read = 1'b0;

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      bit r, iv, rs, rr;
      logic [31:0] a;
      a  = {pool[$urandom_range(0, 6)], 3'($urandom), 2'($urandom)};
      r  = ($urandom_range(0, 99) < 70);
      iv = ($urandom_range(0, 99) < 3);
      rr = ($urandom_range(0, 199) < 1);
      rs = m_busy ? ($urandom_range(0, 99) < 40) : ($urandom_range(0, 99) < 5);
      step(r, a, iv, rs, rr);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
